// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding and slice width.
package nibble_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Index register width: clog2 of the nibble count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// 4-bit ripple-carry slice built from four full-adder bit cells.
// c3 is the carry into bit 3, needed for signed overflow on the top slice.
module nibble_add4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       c3,
   output logic       c4
);

   logic [4:0] c;

   assign c[0] = ci;

   // Full-adder cells chained LSB to MSB.
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign c3 = c[3];
   assign c4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands one nibble per clock, LSB first.
// The carry between nibbles lives in carry_q; results are held until the next start.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last result
// ADD     | one nibble per edge, index idx_q, carry in carry_q
// DONE    | one-cycle done pulse, then back to IDLE
module nibble_serial_adder
   import nibble_pkg::*;
#(
   parameter  int WIDTH   = 16,
   localparam int NIBBLES = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int IDX_W = idx_width(NIBBLES);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [IDX_W+1:0]   sh;
   logic [WIDTH-1:0]   a_shift, b_shift;
   logic [3:0]         s4;
   logic               c3, c4;
   logic               last_nib;

   // Select the current nibble of each captured operand.
   always_comb begin
      sh      = {idx_q, 2'b00};
      a_shift = a_q >> sh;
      b_shift = b_q >> sh;
   end

   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

   nibble_add4 u_add4 (
      .x  (a_shift[NIBBLE_W-1:0]),
      .y  (b_shift[NIBBLE_W-1:0]),
      .ci (carry_q),
      .s  (s4),
      .c3 (c3),
      .c4 (c4)
   );

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               idx_d   = '0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            sum_d   = (sum_q & ~(WIDTH'({NIBBLE_W{1'b1}}) << sh)) | (WIDTH'(s4) << sh);
            carry_d = c4;
            idx_d   = idx_q + 1'b1;
            if (last_nib) begin
               cout_d  = c4;
               ovf_d   = c3 ^ c4;
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_ADD);
      done_d = (state_d == ST_DONE);
   end

   // All state, operand, carry and result registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder that sums two WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first.
- Carry is held in a flop between nibbles; each nibble slice is the same 4-bit ripple-carry function as the lab's RCA4 stage.
- Sits directly upstream of and around the 4-bit adder. It slices wide operands into nibbles, feeds them to the 4-bit adder, and collects the nibble sums into a wide result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived nibble count; not overridden by the user.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress (ADD state).
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB nibble.
- overflow  output  1  signed overflow, equal to (carry into bit WIDTH-1) XOR cout.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE, nibble index to 0, and the carry flop to 0.
  - sum, cout, overflow, busy and done all go to 0 immediately, without waiting for clk.
- States are IDLE, ADD and DONE.
- IDLE:
  - start=1 at a rising edge captures a, b and cin into internal registers.
  - At the same edge: clear sum, set index=0, go to ADD.
  - start=0 keeps the block in IDLE.
- ADD: each edge performs one nibble step.
  - Compute {c4, s4} = a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry.
  - Write sum[4i+3:4i] = s4, set carry = c4, then increment i.
  - On the last nibble (i = NIBBLES-1):
    - cout = c4.
    - overflow = c3 XOR c4, where c3 is the carry into bit 3 of that slice.
    - Next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE unconditionally.
- busy=1 exactly in ADD.
- Latency: start accepted at edge t gives busy high for NIBBLES cycles and done high during the cycle after edge t+NIBBLES. For WIDTH=16, that is 5 cycles from accept to the done edge.
- start outside IDLE (in ADD or DONE) is ignored. Operand registers are unaffected, and changes on a/b/cin mid-operation do not affect the result.
- Back-to-back operation: start held high continuously is accepted again on the first edge in IDLE, i.e. one edge after DONE.
- Output hold: sum, cout and overflow hold their last values in IDLE. They are cleared to 0 on the next accepted start.
- Wrap-around: the result is modulo 2^WIDTH, with the excess reported only in cout.
- rst asserted mid-operation aborts immediately; outputs go to 0 and no done pulse is produced.
- Arithmetic inside the slice is 5-bit unsigned, with no sign extension.
- No X may propagate to outputs after reset.

Decomposition:
- Shared package (nibble_pkg) holds:
  - state encoding constants: ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- Index register width is clog2(NIBBLES), with a minimum of 1.
- One sub-module, nibble_add4: purely combinational 4-bit ripple-carry slice.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], c3 (carry into bit 3), c4.
  - Built from four full-adder bit cells, so it matches the lab adder exactly.
- The top level holds the FSM, operand registers, carry flop and result register.

Test Plan:
- Reset check:
  - Stimulus: assert rst asynchronously mid-cycle with no clk edge.
  - Required: sum=0x0000, cout=0, overflow=0, busy=0, done=0.
- Basic add:
  - Stimulus: a=0x1234, b=0x1111, cin=0, one-cycle start.
  - Required: busy high for 4 cycles; done pulses on the 5th edge; sum=0x2345, cout=0, overflow=0.
- Full carry ripple across nibbles:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0.
  - Required: sum=0x0000, cout=1, overflow=0.
  - Also required: a+0x0000 with cin=1 and a=0x00FF gives 0x0100.
- Signed overflow:
  - Stimulus: a=0x7FFF, b=0x0001.
  - Required: sum=0x8000, cout=0, overflow=1.
  - Also required: 0x8000+0x8000 gives sum=0x0000, cout=1, overflow=1.
- Ignored start and operand stability:
  - Stimulus: issue a second start and change a/b during ADD.
  - Required: the first result is unaffected, only one done pulse occurs, and the result is held in IDLE until the next start.
- Reset mid-operation:
  - Stimulus: assert rst at nibble index 2, deassert, then start 0x0001+0x0002.
  - Required: no done from the aborted op; new sum=0x0003 after 5 edges.
